// File: rtl/reg_select_seq.sv
// Register-select logic for a single-bus datapath: decodes IR fields into one-hot
// register enables, either from manual gra/grb/grc controls or an auto read-read-write sequence.
module reg_select_seq #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS),
   parameter int RA_LSB   = 23,
   parameter int RB_LSB   = 19,
   parameter int RC_LSB   = 15,
   parameter int C_W      = 19,
   parameter int OPC_W    = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [31:0]         ir_in,
   input  logic                ir_load,
   input  logic                gra,
   input  logic                grb,
   input  logic                grc,
   input  logic                rin,
   input  logic                rout,
   input  logic                baout,
   input  logic                start,
   input  logic                use_rc,
   output logic [NUM_REGS-1:0] r_in,
   output logic [NUM_REGS-1:0] r_out,
   output logic                ba_zero,
   output logic [OPC_W-1:0]    opcode,
   output logic [31:0]         c_sext,
   output logic [31:0]         ir_q,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {IDLE, RD_B, RD_C, WR_A} state_t;

   state_t              state_q, state_d;
   logic                use_rc_q, use_rc_d;
   logic [31:0]         ir_d;
   logic [IDX_W-1:0]    ra_idx, rb_idx, rc_idx, sel_idx;
   logic [NUM_REGS-1:0] dec;

   assign ra_idx = ir_q[RA_LSB +: IDX_W];
   assign rb_idx = ir_q[RB_LSB +: IDX_W];
   assign rc_idx = ir_q[RC_LSB +: IDX_W];
   assign opcode = ir_q[31 -: OPC_W];
   assign c_sext = {{(32-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q  <= IDLE;
         use_rc_q <= 1'b0;
         ir_q     <= '0;
      end else begin
         state_q  <= state_d;
         use_rc_q <= use_rc_d;
         ir_q     <= ir_d;
      end
   end

   // IR and use_rc only change in IDLE, so the sequence sees stable fields.
   always_comb begin
      state_d  = state_q;
      use_rc_d = use_rc_q;
      ir_d     = ir_q;
      case (state_q)
         IDLE: begin
            if (ir_load) ir_d = ir_in;
            if (start) begin
               state_d  = RD_B;
               use_rc_d = use_rc;
            end
         end
         RD_B:    state_d = use_rc_q ? RD_C : WR_A;
         RD_C:    state_d = WR_A;
         WR_A:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_idx = '0;
      case (state_q)
         IDLE: begin
            if (gra)      sel_idx = ra_idx;
            else if (grb) sel_idx = rb_idx;
            else if (grc) sel_idx = rc_idx;
         end
         RD_B:    sel_idx = rb_idx;
         RD_C:    sel_idx = rc_idx;
         WR_A:    sel_idx = ra_idx;
         default: sel_idx = '0;
      endcase
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign dec[gi] = (sel_idx == IDX_W'(gi));
   end

   always_comb begin
      r_in    = '0;
      r_out   = '0;
      ba_zero = 1'b0;
      busy    = (state_q != IDLE);
      done    = (state_q == WR_A);
      case (state_q)
         IDLE: begin
            if (rin) r_in = dec;
            // BAout on R0 means a constant zero on the bus, not a register drive.
            if (baout && sel_idx == '0) ba_zero = 1'b1;
            else if (rout || baout)     r_out   = dec;
         end
         RD_B, RD_C: r_out = dec;
         WR_A:       r_in  = dec;
         default:    r_in  = '0;
      endcase
   end

endmodule

// File: tb/tb_reg_select_seq.sv
// Bench for reg_select_seq: directed cases plus random traffic against a queue-based model.
module tb_reg_select_seq;

   localparam int N  = 16;
   localparam int RA = 23;
   localparam int RB = 19;
   localparam int RC = 15;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        clear, ir_load, gra, grb, grc, rin, rout, baout, start, use_rc;
   logic [31:0] ir_in;
   logic [N-1:0] r_in, r_out;
   logic        ba_zero, busy, done;
   logic [4:0]  opcode;
   logic [31:0] c_sext, ir_q;

   reg_select_seq u_dut (
      .clock(clock), .clear(clear), .ir_in(ir_in), .ir_load(ir_load),
      .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
      .start(start), .use_rc(use_rc), .r_in(r_in), .r_out(r_out), .ba_zero(ba_zero),
      .opcode(opcode), .c_sext(c_sext), .ir_q(ir_q), .busy(busy), .done(done)
   );

   // 32-register variant with a wider Ra field.
   logic        w_ir_load, w_gra, w_rin;
   logic [31:0] w_ir_in;
   logic [31:0] w_r_in, w_r_out, w_c_sext, w_ir_q;
   logic        w_ba_zero, w_busy, w_done;
   logic [4:0]  w_opcode;

   reg_select_seq #(.NUM_REGS(32), .IDX_W(5), .RA_LSB(22)) u_dut32 (
      .clock(clock), .clear(clear), .ir_in(w_ir_in), .ir_load(w_ir_load),
      .gra(w_gra), .grb(1'b0), .grc(1'b0), .rin(w_rin), .rout(1'b0), .baout(1'b0),
      .start(1'b0), .use_rc(1'b0), .r_in(w_r_in), .r_out(w_r_out), .ba_zero(w_ba_zero),
      .opcode(w_opcode), .c_sext(w_c_sext), .ir_q(w_ir_q), .busy(w_busy), .done(w_done)
   );

   int n_cmp = 0;
   int n_err = 0;
   int busy_cnt = 0;

   // Model: IR value plus a queue of pending auto phases (1=read B, 2=read C, 3=write A).
   logic [31:0] m_ir = '0;
   int          m_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int fld(input logic [31:0] ir, input int lsb);
      return int'((ir >> lsb) % N);
   endfunction

   task automatic cycle_check();
      logic [31:0] e_rin, e_rout, e_sext;
      logic        e_baz;
      int          idx;
      @(negedge clock);
      e_rin = '0; e_rout = '0; e_baz = 1'b0;
      if (m_q.size() == 0) begin
         idx = gra ? fld(m_ir, RA) : grb ? fld(m_ir, RB) : grc ? fld(m_ir, RC) : 0;
         if (rin) e_rin = 32'(1) << idx;
         if (baout && idx == 0)   e_baz = 1'b1;
         else if (rout || baout)  e_rout = 32'(1) << idx;
      end else if (m_q[0] == 1) e_rout = 32'(1) << fld(m_ir, RB);
      else if (m_q[0] == 2)     e_rout = 32'(1) << fld(m_ir, RC);
      else                      e_rin  = 32'(1) << fld(m_ir, RA);
      e_sext = m_ir[18] ? (m_ir | 32'hFFF8_0000) : (m_ir & 32'h0007_FFFF);
      chk("r_in",    32'(r_in),    e_rin);
      chk("r_out",   32'(r_out),   e_rout);
      chk("ba_zero", 32'(ba_zero), 32'(e_baz));
      chk("busy",    32'(busy),    32'(m_q.size() != 0));
      chk("done",    32'(done),    32'(m_q.size() != 0 && m_q[0] == 3));
      chk("ir_q",    ir_q,         m_ir);
      chk("opcode",  32'(opcode),  m_ir / 32'h0800_0000);
      chk("c_sext",  c_sext,       e_sext);
      if (busy) busy_cnt++;
   endtask

   task automatic cycle_adv();
      @(posedge clock);
      if (clear) begin
         m_ir = '0;
         m_q.delete();
      end else if (m_q.size() == 0) begin
         if (ir_load) m_ir = ir_in;
         if (start) m_q = use_rc ? '{1, 2, 3} : '{1, 3};
      end else begin
         void'(m_q.pop_front());
      end
      #1;
   endtask

   task automatic cycle();
      cycle_check();
      cycle_adv();
   endtask

   task automatic idle_inputs();
      clear = 0; ir_load = 0; gra = 0; grb = 0; grc = 0;
      rin = 0; rout = 0; baout = 0; start = 0; use_rc = 0; ir_in = '0;
   endtask

   initial begin
      idle_inputs();
      clear = 1;
      w_ir_load = 0; w_gra = 0; w_rin = 0; w_ir_in = '0;
      @(posedge clock); #1;
      // reset state
      cycle();
      clear = 0;
      cycle();

      // manual decode of 0x191A0000
      ir_in = 32'h191A_0000; ir_load = 1; cycle();
      ir_load = 0; gra = 1; rin = 1;
      cycle_check();
      chk("d31_opcode", 32'(opcode), 32'd3);
      chk("d31_r_in",   32'(r_in),   32'h0004);
      chk("d31_c_sext", c_sext,      32'h0002_0000);
      cycle_adv();
      gra = 0; rin = 0; grb = 1; rout = 1;
      cycle_check();
      chk("d31_r_out", 32'(r_out), 32'h0008);
      cycle_adv();

      // negative immediate and BAout on R0
      idle_inputs(); ir_in = 32'h0007_FFFF; ir_load = 1; cycle();
      ir_load = 0; grb = 1; baout = 1;
      cycle_check();
      chk("d32_c_sext",  c_sext,         32'hFFFF_FFFF);
      chk("d32_r_out",   32'(r_out),     32'h0000);
      chk("d32_ba_zero", 32'(ba_zero),   32'd1);
      cycle_adv();

      // auto sequence, 3-operand, loaded on the same cycle as start
      idle_inputs(); ir_in = 32'h191A_0000; ir_load = 1; start = 1; use_rc = 1;
      busy_cnt = 0;
      cycle();
      idle_inputs();
      for (int i = 0; i < 4; i++) cycle();
      chk("d33_busy_len", 32'(busy_cnt), 32'd3);

      // auto sequence, 2-operand, ir_load ignored while busy
      start = 1; busy_cnt = 0; cycle();
      idle_inputs(); ir_in = 32'hFFFF_FFFF; ir_load = 1; gra = 1; rin = 1; start = 1;
      cycle();
      idle_inputs(); cycle(); cycle();
      chk("d34_busy_len", 32'(busy_cnt), 32'd2);
      chk("d34_ir_hold",  ir_q, 32'h191A_0000);

      // clear in RD_C aborts
      start = 1; use_rc = 1; cycle();
      idle_inputs(); cycle();
      clear = 1; cycle();
      clear = 0;
      cycle_check();
      chk("d35_busy", 32'(busy), 32'd0);
      chk("d35_ir_q", ir_q, 32'd0);
      chk("d35_r_in", 32'(r_in), 32'd0);
      cycle_adv();

      // 32-register instance, Ra=31
      w_ir_in = 32'd31 << 22; w_ir_load = 1;
      @(posedge clock); #1;
      w_ir_load = 0; w_gra = 1; w_rin = 1;
      @(negedge clock);
      chk("d36_r_in", w_r_in, 32'h8000_0000);
      chk("d36_busy", 32'(w_busy), 32'd0);
      @(posedge clock); #1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         clear   = ($urandom_range(0, 39) == 0);
         ir_load = ($urandom_range(0, 3) == 0);
         ir_in   = $urandom;
         start   = ($urandom_range(0, 5) == 0);
         use_rc  = 1'($urandom);
         gra = 1'($urandom); grb = 1'($urandom); grc = 1'($urandom);
         rin = 1'($urandom); rout = 1'($urandom); baout = 1'($urandom);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
